bayer_demosaic: RTL and testbench

- Converts the RAW8 Bayer pixel stream from the SDRAM frame arbiter (pixel_clk side) into 24-bit RGB for the HDMI transmitter.
- Replaces the current grey replication of `pixel` into `rgb`.
- Uses a one-line buffer and a 2x2 window (up-left, up, left, current) to reconstruct R, G and B at every active pixel.
- Fixed latency of 2 clk_pixel cycles.

---
 rtl/bayer_demosaic.sv | 92 +++++++++
 tb/tb_bayer_demosaic.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/bayer_demosaic.sv
// RAW8 Bayer to 24-bit RGB demosaic: one line buffer feeding a 2x2 window,
// two register stages from pixel input to rgb output.
module bayer_demosaic #(
  parameter int LINE_WIDTH    = 640,
  parameter int BAYER_PATTERN = 0,
  parameter int COORD_WIDTH   = 10
) (
  input  logic                   clk_pixel,
  input  logic                   RESETn,
  input  logic                   pixel_enable,
  input  logic [7:0]             pixel,
  input  logic [COORD_WIDTH-1:0] cx,
  input  logic [COORD_WIDTH-1:0] cy,
  output logic [23:0]            rgb,
  output logic                   rgb_enable
);

  localparam int STAGES = 2;
  localparam int AW     = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
  // CFA index of red; blue sits diagonally opposite, greens at R^1 and R^2
  localparam logic [1:0] R_POS = 2'(BAYER_PATTERN);
  localparam logic [1:0] B_POS = ~R_POS;

  logic [7:0]             mem [0:LINE_WIDTH-1];
  logic [AW-1:0]          addr;
  logic                   in_range, we;

  logic [7:0]             win_a, win_b, win_c, win_d;
  logic [COORD_WIDTH-1:0] cx1, cy1;
  logic                   in_range1;
  logic [STAGES:1]        vld_pipe;

  logic [3:0][7:0]        win;
  logic [1:0]             par;
  logic [8:0]             g_sum;
  logic                   grey;

  assign addr     = cx[AW-1:0];
  assign in_range = int'(cx) < LINE_WIDTH;
  assign we       = pixel_enable & in_range;

  always_ff @(posedge clk_pixel) begin
    if (we) mem[addr] <= pixel;
  end

  // Window only shifts on enabled pixels so blanking gaps keep neighbours intact
  always_ff @(posedge clk_pixel or negedge RESETn) begin
    if (!RESETn) begin
      vld_pipe  <= '0;
      cx1       <= '0;
      cy1       <= '0;
      in_range1 <= 1'b0;
      win_a     <= '0;
      win_b     <= '0;
      win_c     <= '0;
      win_d     <= '0;
    end else begin
      vld_pipe  <= {vld_pipe[STAGES-1:1], pixel_enable};
      cx1       <= cx;
      cy1       <= cy;
      in_range1 <= in_range;
      if (pixel_enable) begin
        win_d <= pixel;
        win_c <= win_d;
        win_a <= win_b;
        win_b <= in_range ? mem[addr] : 8'd0;
      end
    end
  end

  // Offset 0..3 = current, left, up, up-left; a CFA index q lives at q ^ par
  assign win   = {win_a, win_b, win_c, win_d};
  assign par   = {cy1[0], cx1[0]};
  assign g_sum = {1'b0, win[R_POS ^ 2'd1 ^ par]} + {1'b0, win[R_POS ^ 2'd2 ^ par]};
  assign grey  = (cx1 == '0) | (cy1 == '0) | ~in_range1;

  always_ff @(posedge clk_pixel or negedge RESETn) begin
    if (!RESETn) begin
      rgb        <= '0;
      rgb_enable <= 1'b0;
    end else begin
      rgb_enable <= vld_pipe[1];
      if (!vld_pipe[1])
        rgb <= '0;
      else if (grey)
        rgb <= {win_d, win_d, win_d};
      else
        rgb <= {win[R_POS ^ par], g_sum[8:1], win[B_POS ^ par]};
    end
  end

endmodule

// File: tb/tb_bayer_demosaic.sv
// Directed bench for bayer_demosaic: RGGB and BGGR instances on one stream,
// checked every cycle against a coordinate-based reference image model.
module tb_bayer_demosaic;

  logic        clk_pixel = 1'b0;
  logic        RESETn = 1'b1;
  logic        pixel_enable = 1'b0;
  logic [7:0]  pixel = '0;
  logic [9:0]  cx = '0, cy = '0;
  logic [23:0] rgb0, rgb3;
  logic        en0, en3;

  always #5 clk_pixel = ~clk_pixel;

  bayer_demosaic #(.LINE_WIDTH(640), .BAYER_PATTERN(0), .COORD_WIDTH(10)) dut0 (
    .clk_pixel(clk_pixel), .RESETn(RESETn), .pixel_enable(pixel_enable), .pixel(pixel),
    .cx(cx), .cy(cy), .rgb(rgb0), .rgb_enable(en0));

  bayer_demosaic #(.LINE_WIDTH(640), .BAYER_PATTERN(3), .COORD_WIDTH(10)) dut3 (
    .clk_pixel(clk_pixel), .RESETn(RESETn), .pixel_enable(pixel_enable), .pixel(pixel),
    .cx(cx), .cy(cy), .rgb(rgb3), .rgb_enable(en3));

  typedef struct {
    bit          en;
    int          tag, x, y;
    logic [23:0] e0, e3;
  } exp_t;

  exp_t        q[$];
  exp_t        e;
  logic [7:0]  img [0:63][0:639];
  logic [23:0] lit0[int], lit3[int];
  bit          used0[int], used3[int];
  int          tag = 0;
  bit          done = 0;
  int          checks = 0, errors = 0;

  function automatic int key(int t, int x, int y);
    return t * (1 << 20) + y * 1024 + x;
  endfunction

  // 0=R 1=G 2=B, by letter of the pattern name at index {y[0],x[0]}
  function automatic int colour(int pat, int x, int y);
    logic [31:0] word;
    logic [7:0]  ch;
    int          pos;
    pos = ((y & 1) * 2) + (x & 1);
    case (pat)
      0: word = "RGGB";
      1: word = "GRBG";
      2: word = "GBRG";
      default: word = "BGGR";
    endcase
    ch = word[31 - 8 * pos -: 8];
    return (ch == "R") ? 0 : (ch == "G") ? 1 : 2;
  endfunction

  function automatic logic [23:0] model(int pat, bit en, logic [7:0] p, int x, int y);
    int r, b, gs, v, xx, yy;
    if (!en) return 24'h0;
    if (x == 0 || y == 0 || x >= 640) return {p, p, p};
    r = 0; b = 0; gs = 0;
    for (int dy = 0; dy < 2; dy++)
      for (int dx = 0; dx < 2; dx++) begin
        xx = x - dx;
        yy = y - dy;
        v  = (dx == 0 && dy == 0) ? int'(p) : (yy < 64 ? int'(img[yy][xx]) : 0);
        case (colour(pat, xx, yy))
          0: r = v;
          1: gs += v;
          default: b = v;
        endcase
      end
    return {8'(r), 8'(gs / 2), 8'(b)};
  endfunction

  task automatic check(string name, int t, int x, int y, logic [23:0] got, logic [23:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s tag=%0d x=%0d y=%0d got=%h want=%h", name, t, x, y, got, want);
    end
  endtask

  // Single compare process: outputs seen now belong to inputs pushed two negedges ago
  always @(negedge clk_pixel) begin
    if (!RESETn) begin
      check("reset_rgb0", tag, 0, 0, rgb0, 24'h0);
      check("reset_en0", tag, 0, 0, {23'h0, en0}, 24'h0);
      check("reset_rgb3", tag, 0, 0, rgb3, 24'h0);
      q.delete();
    end else begin
      if (q.size() >= 2) begin
        e = q.pop_front();
        check("en0", e.tag, e.x, e.y, {23'h0, en0}, {23'h0, e.en});
        check("rgb0", e.tag, e.x, e.y, rgb0, e.e0);
        check("en3", e.tag, e.x, e.y, {23'h0, en3}, {23'h0, e.en});
        check("rgb3", e.tag, e.x, e.y, rgb3, e.e3);
        if (e.en && lit0.exists(key(e.tag, e.x, e.y)) && !used0.exists(key(e.tag, e.x, e.y))) begin
          used0[key(e.tag, e.x, e.y)] = 1;
          check("model_lit0", e.tag, e.x, e.y, e.e0, lit0[key(e.tag, e.x, e.y)]);
          check("dut_lit0", e.tag, e.x, e.y, rgb0, lit0[key(e.tag, e.x, e.y)]);
        end
        if (e.en && lit3.exists(key(e.tag, e.x, e.y)) && !used3.exists(key(e.tag, e.x, e.y))) begin
          used3[key(e.tag, e.x, e.y)] = 1;
          check("model_lit3", e.tag, e.x, e.y, e.e3, lit3[key(e.tag, e.x, e.y)]);
          check("dut_lit3", e.tag, e.x, e.y, rgb3, lit3[key(e.tag, e.x, e.y)]);
        end
      end else begin
        check("startup_rgb0", tag, 0, 0, rgb0, 24'h0);
        check("startup_en0", tag, 0, 0, {23'h0, en0}, 24'h0);
      end
      e.en  = pixel_enable;
      e.tag = tag;
      e.x   = int'(cx);
      e.y   = int'(cy);
      e.e0  = model(0, pixel_enable, pixel, int'(cx), int'(cy));
      e.e3  = model(3, pixel_enable, pixel, int'(cx), int'(cy));
      q.push_back(e);
      if (pixel_enable && cx < 10'd640 && cy < 10'd64) img[cy][cx] = pixel;
    end
    if (done) begin
      foreach (lit0[k]) if (!used0.exists(k)) check("lit0_unseen", k >> 20, k % 1024, (k >> 10) % 1024, 24'h0, 24'h1);
      foreach (lit3[k]) if (!used3.exists(k)) check("lit3_unseen", k >> 20, k % 1024, (k >> 10) % 1024, 24'h0, 24'h1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
  end

  task automatic drive(bit en, logic [7:0] p, int x, int y);
    pixel_enable = en;
    pixel        = p;
    cx           = x[9:0];
    cy           = y[9:0];
    @(posedge clk_pixel);
    #1;
  endtask

  task automatic idle(int n);
    repeat (n) drive(0, 8'h00, 0, 0);
  endtask

  initial begin
    #1 RESETn = 1'b0;
    for (int i = 0; i < 6; i++) drive(i[0], 8'hAA, i, 0);
    RESETn = 1'b1;

    // 2x2 block: rows (10,20) and (30,40)
    tag = 1;
    lit0[key(1, 0, 0)] = 24'h0A0A0A;
    lit0[key(1, 1, 0)] = 24'h141414;
    lit0[key(1, 0, 1)] = 24'h1E1E1E;
    lit0[key(1, 1, 1)] = 24'h0A1928;
    lit3[key(1, 1, 1)] = 24'h28190A;
    drive(1, 8'd10, 0, 0); drive(1, 8'd20, 1, 0);
    drive(1, 8'd30, 0, 1); drive(1, 8'd40, 1, 1);
    idle(4);

    // extended to three columns
    tag = 2;
    lit0[key(2, 2, 1)] = 24'h322828;
    drive(1, 8'd10, 0, 0); drive(1, 8'd20, 1, 0); drive(1, 8'd50, 2, 0);
    drive(1, 8'd30, 0, 1); drive(1, 8'd40, 1, 1); drive(1, 8'd60, 2, 1);
    idle(4);

    // same data with a 5-cycle blanking gap inside row 1
    tag = 3;
    lit0[key(3, 2, 1)] = 24'h322828;
    drive(1, 8'd10, 0, 0); drive(1, 8'd20, 1, 0); drive(1, 8'd50, 2, 0);
    drive(1, 8'd30, 0, 1); drive(1, 8'd40, 1, 1);
    idle(5);
    drive(1, 8'd60, 2, 1);
    idle(4);

    // green truncation: 255 + 254 -> 254
    tag = 4;
    lit0[key(4, 1, 1)] = 24'h11FE22;
    lit3[key(4, 1, 1)] = 24'h22FE11;
    drive(1, 8'h11, 0, 0); drive(1, 8'hFF, 1, 0);
    drive(1, 8'hFE, 0, 1); drive(1, 8'h22, 1, 1);
    idle(4);

    // ramp frame, full-width lines each ending with an out-of-range cx=640 sample
    tag = 5;
    lit0[key(5, 640, 1)] = 24'hEEEEEE;
    lit3[key(5, 640, 1)] = 24'hEEEEEE;
    lit0[key(5, 1, 2)]   = 24'h0E0C0A;
    lit3[key(5, 1, 2)]   = 24'h0A0C0E;
    for (int y = 0; y < 32; y++) begin
      for (int x = 0; x < 640; x++) drive(1, 8'((x * 3 + y * 7) & 255), x, y);
      drive(1, 8'hEE, 640, y);
      idle(3);
    end
    idle(4);
    done = 1;
    idle(4);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
